// File: rtl/lns_pkg.sv
// Shared LNS definitions: log-field geometry, the sign/zero/log word and the encoder FSM states.
// Imported by the encoder, the decoder and the Gaussian-log correction tables.
package lns_pkg;

    localparam int INT_BITS  = 5;
    localparam int FRAC_BITS = 6;
    localparam int LOG_W     = INT_BITS + FRAC_BITS;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [LOG_W-1:0] log;
    } lns_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } lns_enc_state_t;

    function automatic logic [LOG_W-1:0] pack_log(input logic [INT_BITS-1:0] int_part,
                                                  input logic [FRAC_BITS-1:0] frac_part);
        return {int_part, frac_part};
    endfunction

endpackage

// File: rtl/lns_encoder_lead_one_det.sv
// Combinational priority encoder: index of the most significant set bit plus a non-zero flag.
// Shared with the LNS-to-linear decoder.
module lead_one_det #(
    parameter int W     = 17,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan upward so the highest set bit overwrites any lower ones.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int i = 0; i < W; i++) begin
            idx_o = vec_i[i] ? IDX_W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/lns_encoder.sv
// Sequential linear-to-LNS encoder: leading-one gives the integer log2, then one fractional
// bit per cycle by repeated squaring of the normalised mantissa.
module lns_encoder
    import lns_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic             out_zero,
    output logic [LOG_W-1:0] out_log
);

    localparam int MAG_W = IN_W + 1;
    localparam int IDX_W = $clog2(MAG_W);
    localparam int SQ_W  = MAG_W + 1;
    localparam int CNT_W = $clog2(FRAC_BITS + 1);

    lns_enc_state_t       state_q;
    logic                 sign_q;
    logic                 zero_q;
    logic [MAG_W-1:0]     mag_q;
    logic [MAG_W-1:0]     m_q;
    logic [INT_BITS-1:0]  e_q;
    logic [FRAC_BITS-1:0] frac_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    lns_t                 res_q;

    logic [IDX_W-1:0]     lead_idx_d;
    logic                 lead_vld_d;
    logic [MAG_W-1:0]     mag_in_d;
    logic [MAG_W-1:0]     m_norm_d;
    logic [SQ_W-1:0]      sq_d;
    logic [MAG_W-1:0]     m_d;
    logic                 frac_bit_d;

    lead_one_det #(.W(MAG_W), .IDX_W(IDX_W)) u_lod (
        .vec_i   (mag_q),
        .idx_o   (lead_idx_d),
        .valid_o (lead_vld_d)
    );

    // Magnitude, normalisation shift and one squaring step (Q1.IN_W squared, truncated to Q2.IN_W).
    always_comb begin
        mag_in_d   = '0;
        m_norm_d   = '0;
        sq_d       = '0;
        m_d        = '0;
        frac_bit_d = 1'b0;
        if (in_data[IN_W-1]) begin
            mag_in_d = MAG_W'(0) - {in_data[IN_W-1], in_data};
        end else begin
            mag_in_d = {1'b0, in_data};
        end
        m_norm_d = mag_q << (IDX_W'(IN_W) - lead_idx_d);
        sq_d = SQ_W'(({{MAG_W{1'b0}}, m_q} * {{MAG_W{1'b0}}, m_q}) >> IN_W);
        if (sq_d[SQ_W-1]) begin
            frac_bit_d = 1'b1;
            m_d        = sq_d[SQ_W-1:1];
        end else begin
            frac_bit_d = 1'b0;
            m_d        = sq_d[MAG_W-1:0];
        end
    end

    // Encoder FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            m_q         <= '0;
            e_q         <= '0;
            frac_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_data[IN_W-1];
                        mag_q      <= mag_in_d;
                        zero_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    // A zero operand spends a second cycle here to keep its fixed two-edge latency.
                    if (!lead_vld_d) begin
                        if (zero_q) begin
                            res_q.sign  <= 1'b0;
                            res_q.zero  <= 1'b1;
                            res_q.log   <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            zero_q <= 1'b1;
                        end
                    end else begin
                        e_q     <= INT_BITS'(lead_idx_d);
                        frac_q  <= '0;
                        m_q     <= m_norm_d;
                        cnt_q   <= '0;
                        state_q <= FRAC;
                    end
                end
                FRAC: begin
                    m_q    <= m_d;
                    frac_q <= {frac_q[FRAC_BITS-2:0], frac_bit_d};
                    if (cnt_q == CNT_W'(FRAC_BITS - 1)) begin
                        res_q.sign  <= sign_q;
                        res_q.zero  <= 1'b0;
                        res_q.log   <= pack_log(e_q, {frac_q[FRAC_BITS-2:0], frac_bit_d});
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sign  = res_q.sign;
    assign out_zero  = res_q.zero;
    assign out_log   = res_q.log;

endmodule

// File: tb/tb_lns_encoder.sv
// Directed table plus corner-case sequences and a random stream for the linear-to-LNS encoder.
module tb_lns_encoder;
    import lns_pkg::*;

    localparam int IN_W = 16;
    localparam int N_RAND = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic             out_zero;
    logic [LOG_W-1:0] out_log;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        sign;
        logic        zero;
        logic [10:0] log;
        int          lat;
    } vec_t;

    vec_t tbl[10];
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    lns_encoder #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_log   (out_log)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: integer log2 by leading one, then six truncated squarings in Q1.16.
    function automatic logic [12:0] ref_enc(input logic [15:0] x);
        int v;
        int mag;
        int e;
        int frac;
        longint m;
        longint p;
        v = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag == 0) return {1'b0, 1'b1, 11'd0};
        e = 0;
        for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) e = i;
        m = longint'(mag) << (16 - e);
        frac = 0;
        for (int k = 0; k < 6; k++) begin
            p = (m * m) >> 16;
            if (p >= 64'sd131072) begin
                frac = frac * 2 + 1;
                m = p >> 1;
            end else begin
                frac = frac * 2;
                m = p;
            end
        end
        return {(v < 0) ? 1'b1 : 1'b0, 1'b0, 11'(e * 64 + frac)};
    endfunction

    task automatic send(input logic [15:0] d, output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        ok = in_ready;
        if (!ok) return;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire_out_valid", out_valid, 0);
        check("retire_in_ready", in_ready, 1);
    endtask

    initial begin
        bit ok;
        int lat;
        int got;
        int cyc;
        bit drv_done;

        tbl[0] = '{16'd1,     1'b0, 1'b0, 11'd0,   7};
        tbl[1] = '{16'd3,     1'b0, 1'b0, 11'd101, 7};
        tbl[2] = '{16'hFFF8,  1'b1, 1'b0, 11'd192, 7};
        tbl[3] = '{16'd5,     1'b0, 1'b0, 11'd148, 7};
        tbl[4] = '{16'd100,   1'b0, 1'b0, 11'd425, 7};
        tbl[5] = '{16'hFF9C,  1'b1, 1'b0, 11'd425, 7};
        tbl[6] = '{16'd32767, 1'b0, 1'b0, 11'd959, 7};
        tbl[7] = '{16'd4,     1'b0, 1'b0, 11'd128, 7};
        tbl[8] = '{16'd0,     1'b0, 1'b1, 11'd0,   2};
        tbl[9] = '{16'h8000,  1'b1, 1'b0, 11'd960, 7};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sign", out_sign, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_log", out_log, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].data, ok);
            check("busy_in_ready", in_ready, 0);
            wait_valid(lat);
            check("latency", lat, tbl[i].lat);
            check("sign", out_sign, tbl[i].sign);
            check("zero", out_zero, tbl[i].zero);
            check("log", out_log, tbl[i].log);
            retire();
        end

        // Reset during FRAC of operand 3, then operand 2 with normal latency.
        send(16'd3, ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sign", out_sign, 0);
        check("midrst_out_zero", out_zero, 0);
        check("midrst_out_log", out_log, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", out_valid, 0);
        end
        send(16'd2, ok);
        wait_valid(lat);
        check("after_rst_latency", lat, 7);
        check("after_rst_log", out_log, 64);
        retire();

        // Zero operand held in DONE; an in_valid pulse meanwhile must be ignored.
        send(16'd0, ok);
        wait_valid(lat);
        check("zero_latency", lat, 2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_valid = 1'b1;
                in_data  = 16'd5;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_zero", out_zero, 1);
            check("hold_out_sign", out_sign, 0);
            check("hold_out_log", out_log, 0);
            check("hold_in_ready", in_ready, 0);
        end
        retire();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("ignored_no_valid", out_valid, 0);
        end

        // Random back-to-back stream with random out_ready.
        got = 0;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < N_RAND; i++) begin
                    logic [15:0] d;
                    int n;
                    d = 16'($urandom);
                    n = 0;
                    while (!in_ready && n < 300) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (!in_ready) begin
                        errors++;
                        $display("FAIL rand_drive_timeout actual=%0d required=%0d", i, N_RAND);
                        break;
                    end
                    exp_q.push_back(ref_enc(d));
                    in_valid = 1'b1;
                    in_data  = d;
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin
                cyc = 0;
                while (got < N_RAND && cyc < 60000 && !(drv_done && exp_q.size() == 0 && !out_valid)) begin
                    @(posedge clk); #1;
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_duplicate actual=%0d required=%0d", got + 1, got);
                        end else begin
                            check("rand_result", {out_sign, out_zero, out_log}, exp_q.pop_front());
                        end
                        got++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("rand_count", got, N_RAND);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
